// File: rtl/requant_pkg.sv
// requant_pkg: shared constants and helpers for the requantiser pipeline.
// Provides rounding-mode codes, output saturation limits and a popcount.
package requant_pkg;

    localparam logic [1:0] RM_FLOOR     = 2'd0;
    localparam logic [1:0] RM_HALF_UP   = 2'd1;
    localparam logic [1:0] RM_HALF_EVEN = 2'd2;

    typedef struct packed {
        logic signed [63:0] hi;
        logic signed [63:0] lo;
    } sat_lim_t;

    // Largest and smallest value representable in an out_w-bit signed word.
    function automatic sat_lim_t sat_limits(input int out_w);
        sat_lim_t l;
        l.hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        l.lo = -(64'sd1 <<< (out_w - 1));
        return l;
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane: one lane of shift / round / saturate, split into S1 and S2.
// Ports: clk, rst_n, s1_en_i/s2_en_i stage loads, x_i, shift_i, rmode_i in; y_o, sat_o out.
module requant_lane
    import requant_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s1_en_i,
    input  logic               s2_en_i,
    input  logic [IN_W-1:0]    x_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [1:0]         rmode_i,
    output logic [OUT_W-1:0]   y_o,
    output logic               sat_o
);

    // One guard bit so that q + 1 can never wrap.
    localparam int W1 = IN_W + 1;
    localparam sat_lim_t LIM = sat_limits(OUT_W);
    localparam logic signed [W1-1:0] HI = W1'(LIM.hi);
    localparam logic signed [W1-1:0] LO = W1'(LIM.lo);

    logic signed [W1-1:0] xe;
    logic signed [W1-1:0] q_d;
    logic signed [W1-1:0] q_q;
    logic signed [W1-1:0] inc_w;
    logic signed [W1-1:0] sum;
    logic [IN_W-1:0]      hmask;
    logic [IN_W-1:0]      bmask;
    logic                 half;
    logic                 rest;
    logic                 inc_d;
    logic                 inc_q;
    logic [OUT_W-1:0]     y_d;
    logic [OUT_W-1:0]     y_q;
    logic                 sat_d;
    logic                 sat_q;

    // S1: shift and decide the rounding increment.
    always_comb begin
        xe    = {x_i[IN_W-1], x_i};
        q_d   = xe >>> shift_i;
        // hmask selects bit s-1 (zero when s=0, which disables rounding).
        hmask = (IN_W'(1) << shift_i) >> 1;
        // bmask selects bits below s-1 (don't care when s=0).
        bmask = hmask - IN_W'(1);
        half  = |(x_i & hmask);
        rest  = |(x_i & bmask);
        inc_d = 1'b0;
        unique case (1'b1)
            (rmode_i == RM_FLOOR):     inc_d = 1'b0;
            (rmode_i == RM_HALF_EVEN): inc_d = half & (rest | q_d[0]);
            default:                   inc_d = half;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            inc_q <= 1'b0;
        end else if (s1_en_i) begin
            q_q   <= q_d;
            inc_q <= inc_d;
        end
    end

    // S2: apply increment and clamp to the output range.
    always_comb begin
        inc_w = W1'(inc_q);
        sum   = q_q + inc_w;
        y_d   = sum[OUT_W-1:0];
        sat_d = 1'b0;
        if (sum > HI) begin
            y_d   = HI[OUT_W-1:0];
            sat_d = 1'b1;
        end else if (sum < LO) begin
            y_d   = LO[OUT_W-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sat_q <= 1'b0;
        end else if (s2_en_i) begin
            y_q   <= y_d;
            sat_q <= sat_d;
        end
    end

    assign y_o   = y_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/requant_shifter_pipe.sv
// requant_shifter_pipe: LANES-wide 2-stage requantiser with valid/ready flow and sat stats.
// Ports: in_* beat (data, shift, rmode), out_* beat (data, sat), sat_clr/sat_count.
// Build option REQUANT_PER_LANE_SHIFT_EN: in_shift carries one SHIFT_W field per lane.
module requant_shifter_pipe
    import requant_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    in_data,
`ifdef REQUANT_PER_LANE_SHIFT_EN
    input  logic [LANES*SHIFT_W-1:0] in_shift,
`else
    input  logic [SHIFT_W-1:0]       in_shift,
`endif
    input  logic [1:0]               in_rmode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [LANES-1:0]         out_sat,
    input  logic                     sat_clr,
    output logic [CNT_W-1:0]         sat_count
);

    if ((2 ** SHIFT_W) > IN_W) begin : g_bad_shift
        $error("requant_shifter_pipe: 2**SHIFT_W must not exceed IN_W");
    end
    if (OUT_W >= IN_W) begin : g_bad_out
        $error("requant_shifter_pipe: OUT_W must be below IN_W");
    end

    logic             init_q;
    logic             s1_valid_q;
    logic             s1_valid_d;
    logic             s2_valid_q;
    logic             s2_valid_d;
    logic             s2_adv;
    logic             s2_en;
    logic             acc;
    logic             xfer;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // init_q keeps in_ready low until the first clock after reset release.
    always_comb begin
        s2_adv     = ~s2_valid_q | out_ready;
        in_ready   = init_q & (~s1_valid_q | s2_adv);
        acc        = in_valid & in_ready;
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_en      = s2_adv & s1_valid_q;
        xfer       = s2_valid_q & out_ready;
        cnt_sum    = {1'b0, cnt_q}
                   + (CNT_W+1)'(popcount(64'(out_sat)));
        cnt_d      = cnt_q;
        if (sat_clr) begin
            cnt_d = '0;
        end else if (xfer) begin
            cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            init_q     <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [SHIFT_W-1:0] sh;
`ifdef REQUANT_PER_LANE_SHIFT_EN
        assign sh = in_shift[i*SHIFT_W +: SHIFT_W];
`else
        assign sh = in_shift;
`endif
        requant_lane #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .s1_en_i (acc),
            .s2_en_i (s2_en),
            .x_i     (in_data[i*IN_W +: IN_W]),
            .shift_i (sh),
            .rmode_i (in_rmode),
            .y_o     (out_data[i*OUT_W +: OUT_W]),
            .sat_o   (out_sat[i])
        );
    end

    assign out_valid = s2_valid_q;
    assign sat_count = cnt_q;

endmodule

// File: tb/tb_requant_shifter_pipe.sv
// tb_requant_shifter_pipe: random and directed stimulus against a reference model.
// Scoreboard of expected beats plus a sat_count model.
module tb_requant_shifter_pipe;

    localparam int LANES   = 8;
    localparam int IN_W    = 32;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 16;
`ifdef REQUANT_PER_LANE_SHIFT_EN
    localparam int SHW = LANES * SHIFT_W;
`else
    localparam int SHW = SHIFT_W;
`endif
    localparam int EW      = LANES + LANES * OUT_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [EW-1:0]         exp_t;
    typedef logic [LANES*IN_W-1:0] din_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid;
    logic                   in_ready;
    din_t                   in_data;
    logic [SHW-1:0]         in_shift;
    logic [1:0]             in_rmode;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_sat;
    logic                   sat_clr;
    logic [CNT_W-1:0]       sat_count;

    logic rnd_rdy = 1'b0;
    logic rdy_rnd = 1'b1;
    logic rdy_man = 1'b1;
    assign out_ready = rnd_rdy ? rdy_rnd : rdy_man;

    always #5 clk = ~clk;

    requant_shifter_pipe #(
        .LANES   (LANES),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_rmode  (in_rmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    int total = 0;
    int bad   = 0;
    int nout  = 0;
    int stalls = 0;
    int mdl_cnt = 0;
    exp_t exp_q[$];
    logic held_v = 1'b0;
    logic [EW:0] held;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: floor by arithmetic shift, rounding decided from the
    // remainder compared against half of the divisor.
    function automatic logic [OUT_W:0] ref_lane(input longint x,
                                                input int s, input int m);
        longint p, q, rem, r, hi, lo;
        logic up;
        p   = 64'sd1 <<< s;
        q   = x >>> s;
        rem = x - q * p;
        hi  = (64'sd1 <<< (OUT_W - 1)) - 1;
        lo  = -hi - 1;
        up  = 1'b0;
        if (s != 0) begin
            if (m == 1 || m == 3) up = (2 * rem >= p);
            else if (m == 2)
                up = (2 * rem > p) || (2 * rem == p && (q & 1) != 0);
        end
        r = q + (up ? 64'sd1 : 64'sd0);
        if (r > hi) return {1'b1, hi[OUT_W-1:0]};
        if (r < lo) return {1'b1, lo[OUT_W-1:0]};
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    function automatic exp_t model_beat(input din_t d,
                                        input logic [SHW-1:0] sh,
                                        input logic [1:0] m);
        exp_t e;
        logic [OUT_W:0] r;
        int s;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef REQUANT_PER_LANE_SHIFT_EN
            s = int'(sh[i*SHIFT_W +: SHIFT_W]);
`else
            s = int'(sh);
`endif
            r = ref_lane(longint'($signed(d[i*IN_W +: IN_W])), s, int'(m));
            e[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
            e[LANES*OUT_W + i]  = r[OUT_W];
        end
        return e;
    endfunction

    function automatic logic [SHW-1:0] mk_sh(input int s);
        logic [SHW-1:0] sh;
`ifdef REQUANT_PER_LANE_SHIFT_EN
        for (int i = 0; i < LANES; i++) sh[i*SHIFT_W +: SHIFT_W] = SHIFT_W'(s);
`else
        sh = SHIFT_W'(s);
`endif
        return sh;
    endfunction

    function automatic din_t rand_data();
        din_t d;
        logic [31:0] v;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom_range(0, 8191) - 32'd4096;
                2: v = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                default: v = $urandom_range(0, 511) - 32'd256;
            endcase
            d[i*IN_W +: IN_W] = v;
        end
        return d;
    endfunction

    function automatic din_t sat_data(input int nsat);
        din_t d;
        for (int i = 0; i < LANES; i++) begin
            if (i < nsat)
                d[i*IN_W +: IN_W] = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            else
                d[i*IN_W +: IN_W] = 32'd5;
        end
        return d;
    endfunction

    task automatic send_beat(input din_t d, input logic [SHW-1:0] sh,
                             input logic [1:0] m, input exp_t e);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_shift = sh;
        in_rmode = m;
        exp_q.push_back(e);
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        stalls += n;
        if (n >= 200) chk("in_ready_timeout", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_model(input din_t d, input logic [SHW-1:0] sh,
                              input logic [1:0] m);
        send_beat(d, sh, m, model_beat(d, sh, m));
    endtask

    task automatic send_rand();
        logic [SHW-1:0] sh;
        sh = SHW'({$urandom, $urandom});
        send_model(rand_data(), sh, 2'($urandom_range(0, 3)));
    endtask

    task automatic drain();
        int n;
        rnd_rdy = 1'b0;
        rdy_man = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) rdy_rnd = 1'($urandom_range(0, 1));

    // Output monitor: scoreboard, hold-while-stalled and sat_count model.
    always @(negedge clk) begin
        exp_t e;
        int pc;
        #2;
        if (!rst_n) begin
            held_v = 1'b0;
            exp_q.delete();
            mdl_cnt = 0;
        end else begin
            chk("sat_count", 128'(sat_count), 128'(mdl_cnt));
            if (held_v)
                chk("hold", 128'({out_valid, out_sat, out_data}), 128'(held));
            held_v = out_valid && !out_ready;
            held   = {out_valid, out_sat, out_data};
            pc = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 128'(out_valid), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 128'({out_sat, out_data}), 128'(e));
                    pc = $countones(e[EW-1 -: LANES]);
                    nout++;
                end
            end
            if (sat_clr) mdl_cnt = 0;
            else if (mdl_cnt + pc > CNT_MAX) mdl_cnt = CNT_MAX;
            else mdl_cnt += pc;
        end
    end

    localparam int ND = 15;
    int dx[ND] = '{40, 40, 40, 40, 56, -40, -40, -40,
                   32'h7FFF_FFFF, 32'h8000_0000, -128,
                   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 24};
    int ds[ND] = '{4, 4, 4, 4, 4, 4, 4, 4, 0, 0, 0, 31, 31, 0, 4};
    int dm[ND] = '{0, 1, 2, 3, 2, 0, 1, 2, 0, 0, 0, 1, 0, 1, 2};
    int dy[ND] = '{2, 3, 2, 3, 4, -3, -2, -2, 127, -128, -128, 1, 0, 127, 2};
    int df[ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0};

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        logic saw_block;
        din_t d;
        exp_t e;
        in_valid = 1'b0;
        in_data  = '0;
        in_shift = '0;
        in_rmode = 2'd0;
        sat_clr  = 1'b0;

        #12;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_sat", 128'(out_sat), 128'(0));
        chk("rst_sat_count", 128'(sat_count), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        for (int k = 0; k < ND; k++) begin
            d = {LANES{32'(dx[k])}};
            e = {{LANES{1'(df[k])}}, {LANES{8'(dy[k])}}};
            send_beat(d, mk_sh(ds[k]), 2'(dm[k]), e);
        end
        drain();

        n0 = nout;
        saw_block = 1'b0;
        fork
            begin
                repeat (6) send_rand();
            end
            begin
                repeat (2) @(negedge clk);
                rdy_man = 1'b0;
                repeat (4) begin
                    #1;
                    if (!in_ready) saw_block = 1'b1;
                    @(negedge clk);
                end
                rdy_man = 1'b1;
            end
        join
        drain();
        chk("bp_count", 128'(nout - n0), 128'(6));
        chk("bp_block", 128'(saw_block), 128'(1));

        stalls = 0;
        n0 = nout;
        repeat (16) send_rand();
        chk("tput_stalls", 128'(stalls), 128'(0));
        drain();
        chk("tput_count", 128'(nout - n0), 128'(16));

        rnd_rdy = 1'b1;
        repeat (300) send_rand();
        drain();

        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        repeat (3) send_model(sat_data(2), mk_sh(0), 2'd0);
        drain();
        chk("cnt_six", 128'(sat_count), 128'(6));
        rdy_man = 1'b0;
        send_model(sat_data(2), mk_sh(0), 2'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_out_valid", 128'(out_valid), 128'(1));
        sat_clr = 1'b1;
        rdy_man = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        #3;
        chk("clr_with_xfer", 128'(sat_count), 128'(0));
        drain();

        repeat (8191) send_model(sat_data(8), mk_sh(0), 2'd0);
        send_model(sat_data(6), mk_sh(0), 2'd0);
        drain();
        chk("cnt_fffe", 128'(sat_count), 128'(16'hFFFE));
        send_model(sat_data(3), mk_sh(0), 2'd0);
        drain();
        chk("cnt_sticky1", 128'(sat_count), 128'(16'hFFFF));
        send_model(sat_data(3), mk_sh(0), 2'd0);
        drain();
        chk("cnt_sticky2", 128'(sat_count), 128'(16'hFFFF));

        rdy_man = 1'b0;
        send_model(sat_data(2), mk_sh(0), 2'd0);
        send_model(sat_data(4), mk_sh(0), 2'd0);
        n0 = nout;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_sat_count", 128'(sat_count), 128'(0));
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        rdy_man = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_stale", 128'(nout - n0), 128'(0));
        #1;
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        repeat (4) send_rand();
        drain();
        chk("post_rst_count", 128'(nout - n0), 128'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
